// File: rtl/operand_fetch.sv
// Operand fetch stage: drives regfile read/write ports, bypasses writeback data,
// tracks busy registers to stall RAW/WAW hazards, and registers operands for execute.
module operand_fetch #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   id_valid_i,
    output logic                   id_ready_o,
    input  logic [ADDR_W-1:0]      id_src_a_i,
    input  logic [ADDR_W-1:0]      id_src_b_i,
    input  logic [ADDR_W-1:0]      id_dst_i,
    input  logic                   id_has_dst_i,
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output logic [DATA_W-1:0]      ex_op_a_o,
    output logic [DATA_W-1:0]      ex_op_b_o,
    output logic [ADDR_W-1:0]      ex_dst_o,
    output logic                   ex_has_dst_o,
    input  logic                   wb_valid_i,
    input  logic [ADDR_W-1:0]      wb_rc_i,
    input  logic [DATA_W-1:0]      wb_data_i,
    output logic [ADDR_W-1:0]      rf_ra_o,
    output logic [ADDR_W-1:0]      rf_rb_o,
    output logic [ADDR_W-1:0]      rf_rc_o,
    output logic                   rf_write_enable_o,
    output logic [DATA_W-1:0]      rf_write_data_o,
    input  logic [DATA_W-1:0]      rf_read_data_a_i,
    input  logic [DATA_W-1:0]      rf_read_data_b_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic                   ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]      ex_op_a_q, ex_op_a_d;
    logic [DATA_W-1:0]      ex_op_b_q, ex_op_b_d;
    logic [ADDR_W-1:0]      ex_dst_q, ex_dst_d;
    logic                   ex_has_dst_q, ex_has_dst_d;
    logic [NREGS-1:0]       busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic              fwd_a, fwd_b, wb_hits_dst;
    logic              raw_a, raw_b, waw, hazard, issue;
    logic [DATA_W-1:0] op_a, op_b;

    assign rf_ra_o           = id_src_a_i;
    assign rf_rb_o           = id_src_b_i;
    assign rf_rc_o           = wb_rc_i;
    assign rf_write_data_o   = wb_data_i;
    assign rf_write_enable_o = rst_ni && wb_valid_i;

    // A writeback landing this cycle both supplies the operand and releases the hazard.
    assign fwd_a       = wb_valid_i && (wb_rc_i == id_src_a_i);
    assign fwd_b       = wb_valid_i && (wb_rc_i == id_src_b_i);
    assign wb_hits_dst = wb_valid_i && (wb_rc_i == id_dst_i);
    assign op_a        = fwd_a ? wb_data_i : rf_read_data_a_i;
    assign op_b        = fwd_b ? wb_data_i : rf_read_data_b_i;

    assign raw_a  = busy_q[id_src_a_i] && !fwd_a;
    assign raw_b  = busy_q[id_src_b_i] && !fwd_b;
    assign waw    = id_has_dst_i && busy_q[id_dst_i] && !wb_hits_dst;
    assign hazard = id_valid_i && (raw_a || raw_b || waw);

    assign id_ready_o = rst_ni && !hazard && (!ex_valid_q || ex_ready_i);
    assign issue      = id_valid_i && id_ready_o;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_a_d    = ex_op_a_q;
        ex_op_b_d    = ex_op_b_q;
        ex_dst_d     = ex_dst_q;
        ex_has_dst_d = ex_has_dst_q;
        busy_d       = busy_q;
        stall_cnt_d  = stall_cnt_q;

        if (issue) begin
            ex_valid_d   = 1'b1;
            ex_op_a_d    = op_a;
            ex_op_b_d    = op_b;
            ex_dst_d     = id_dst_i;
            ex_has_dst_d = id_has_dst_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end

        // Clear first so a same-register set in this cycle takes priority.
        if (wb_valid_i) begin
            busy_d[wb_rc_i] = 1'b0;
        end
        if (issue && id_has_dst_i) begin
            busy_d[id_dst_i] = 1'b1;
        end

        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_dst_q     <= '0;
            ex_has_dst_q <= 1'b0;
            busy_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_a_q    <= ex_op_a_d;
            ex_op_b_q    <= ex_op_b_d;
            ex_dst_q     <= ex_dst_d;
            ex_has_dst_q <= ex_has_dst_d;
            busy_q       <= busy_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_op_a_o    = ex_op_a_q;
    assign ex_op_b_o    = ex_op_b_q;
    assign ex_dst_o     = ex_dst_q;
    assign ex_has_dst_o = ex_has_dst_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 8x32 regfile attached to its ports.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready, id_has_dst;
    logic [2:0]  id_src_a, id_src_b, id_dst;
    logic        ex_valid, ex_ready, ex_has_dst;
    logic [31:0] ex_op_a, ex_op_b;
    logic [2:0]  ex_dst;
    logic        wb_valid;
    logic [2:0]  wb_rc;
    logic [31:0] wb_data;
    logic [2:0]  rf_ra, rf_rb, rf_rc;
    logic        rf_write_enable;
    logic [31:0] rf_write_data, rf_read_data_a, rf_read_data_b;
    logic [3:0]  stall_cnt;

    logic [31:0] rf [8];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_write_enable) rf[rf_rc] <= rf_write_data;
    assign rf_read_data_a = rf[rf_ra];
    assign rf_read_data_b = rf[rf_rb];

    operand_fetch #(.DATA_W(32), .ADDR_W(3), .STALL_CNT_W(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .id_valid_i       (id_valid),
        .id_ready_o       (id_ready),
        .id_src_a_i       (id_src_a),
        .id_src_b_i       (id_src_b),
        .id_dst_i         (id_dst),
        .id_has_dst_i     (id_has_dst),
        .ex_valid_o       (ex_valid),
        .ex_ready_i       (ex_ready),
        .ex_op_a_o        (ex_op_a),
        .ex_op_b_o        (ex_op_b),
        .ex_dst_o         (ex_dst),
        .ex_has_dst_o     (ex_has_dst),
        .wb_valid_i       (wb_valid),
        .wb_rc_i          (wb_rc),
        .wb_data_i        (wb_data),
        .rf_ra_o          (rf_ra),
        .rf_rb_o          (rf_rb),
        .rf_rc_o          (rf_rc),
        .rf_write_enable_o(rf_write_enable),
        .rf_write_data_o  (rf_write_data),
        .rf_read_data_a_i (rf_read_data_a),
        .rf_read_data_b_i (rf_read_data_b),
        .stall_cnt_o      (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic hd);
        id_valid = v; id_src_a = a; id_src_b = b; id_dst = d; id_has_dst = hd;
    endtask

    task automatic set_wb(input logic v, input logic [2:0] rc, input logic [31:0] data);
        wb_valid = v; wb_rc = rc; wb_data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_ready = 1'b1;
        set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1);
        set_wb(1'b1, 3'd5, 32'h99);
        tick(); tick(); #1;
        n_chk++; if (id_ready !== 1'b0) $display("FAIL reset_id_ready got %0h exp 0", id_ready); else n_pass++;
        n_chk++; if (rf_write_enable !== 1'b0) $display("FAIL reset_rf_we got %0h exp 0", rf_write_enable); else n_pass++;
        n_chk++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0h exp 0", ex_valid); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h00) $display("FAIL reset_busy got %0h exp 00", dut.busy_q); else n_pass++;
        rst_n = 1'b1;
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        set_wb(1'b0, 3'd0, 32'h0);
        tick();
        n_chk++; if (rf[5] !== 32'h0) $display("FAIL reset_no_write got %0h exp 0", rf[5]); else n_pass++;
    endtask

    task automatic test_issue();
        set_wb(1'b1, 3'd1, 32'd5); #1;
        n_chk++; if (rf_write_enable !== 1'b1 || rf_rc !== 3'd1) $display("FAIL wb_drive got we=%0h rc=%0d exp we=1 rc=1", rf_write_enable, rf_rc); else n_pass++;
        tick();
        set_wb(1'b1, 3'd2, 32'd7); tick();
        set_wb(1'b0, 3'd0, 32'h0);
        ex_ready = 1'b0;
        set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1); #1;
        n_chk++; if (rf_ra !== 3'd1 || rf_rb !== 3'd2) $display("FAIL issue_raddr got %0d/%0d exp 1/2", rf_ra, rf_rb); else n_pass++;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL issue_id_ready got %0h exp 1", id_ready); else n_pass++;
        tick();
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_valid !== 1'b1) $display("FAIL issue_ex_valid got %0h exp 1", ex_valid); else n_pass++;
        n_chk++; if (ex_op_a !== 32'd5 || ex_op_b !== 32'd7) $display("FAIL issue_ops got %0h/%0h exp 5/7", ex_op_a, ex_op_b); else n_pass++;
        n_chk++; if (ex_dst !== 3'd3 || ex_has_dst !== 1'b1) $display("FAIL issue_dst got %0d/%0h exp 3/1", ex_dst, ex_has_dst); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h08) $display("FAIL issue_busy got %0h exp 08", dut.busy_q); else n_pass++;
    endtask

    task automatic test_raw();
        ex_ready = 1'b1;
        set_id(1'b1, 3'd3, 3'd1, 3'd0, 1'b0); #1;
        n_chk++; if (id_ready !== 1'b0) $display("FAIL raw_stall got %0h exp 0", id_ready); else n_pass++;
        tick();
        n_chk++; if (stall_cnt !== 4'd1) $display("FAIL raw_stall_cnt got %0d exp 1", stall_cnt); else n_pass++;
        set_wb(1'b1, 3'd3, 32'h1234); #1;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL raw_bypass_ready got %0h exp 1", id_ready); else n_pass++;
        tick();
        set_wb(1'b0, 3'd0, 32'h0);
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_valid !== 1'b1) $display("FAIL raw_ex_valid got %0h exp 1", ex_valid); else n_pass++;
        n_chk++; if (ex_op_a !== 32'h1234 || ex_op_b !== 32'd5) $display("FAIL raw_bypass_ops got %0h/%0h exp 1234/5", ex_op_a, ex_op_b); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h00) $display("FAIL raw_busy_clear got %0h exp 00", dut.busy_q); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd1) $display("FAIL raw_cnt_hold got %0d exp 1", stall_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        set_id(1'b1, 3'd1, 3'd2, 3'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (id_ready !== 1'b0) $display("FAIL bp_id_ready[%0d] got %0h exp 0", i, id_ready); else n_pass++;
            n_chk++; if (ex_valid !== 1'b1 || ex_op_a !== 32'h1234 || ex_dst !== 3'd0) $display("FAIL bp_hold[%0d] got v=%0h a=%0h d=%0d exp 1/1234/0", i, ex_valid, ex_op_a, ex_dst); else n_pass++;
            tick();
        end
        ex_ready = 1'b1; #1;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL bp_release got %0h exp 1", id_ready); else n_pass++;
        tick();
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_op_a !== 32'd5 || ex_op_b !== 32'd7 || ex_dst !== 3'd5) $display("FAIL bp_next got %0h/%0h/%0d exp 5/7/5", ex_op_a, ex_op_b, ex_dst); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h20) $display("FAIL bp_busy got %0h exp 20", dut.busy_q); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd1) $display("FAIL bp_no_count got %0d exp 1", stall_cnt); else n_pass++;
    endtask

    task automatic test_waw();
        ex_ready = 1'b1;
        set_id(1'b1, 3'd0, 3'd0, 3'd4, 1'b1); #1;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL waw_first got %0h exp 1", id_ready); else n_pass++;
        tick(); #1;
        n_chk++; if (id_ready !== 1'b0) $display("FAIL waw_stall got %0h exp 0", id_ready); else n_pass++;
        tick();
        n_chk++; if (stall_cnt !== 4'd2) $display("FAIL waw_cnt got %0d exp 2", stall_cnt); else n_pass++;
        set_wb(1'b1, 3'd4, 32'hAA); #1;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL waw_wb_ready got %0h exp 1", id_ready); else n_pass++;
        tick();
        set_wb(1'b0, 3'd0, 32'h0);
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (dut.busy_q !== 8'h30 || ex_dst !== 3'd4) $display("FAIL waw_set_wins got busy=%0h dst=%0d exp 30/4", dut.busy_q, ex_dst); else n_pass++;
        // r2 = r2 + r2 with r2 idle must issue straight away
        set_id(1'b1, 3'd2, 3'd2, 3'd2, 1'b1); #1;
        n_chk++; if (id_ready !== 1'b1) $display("FAIL selfref_ready got %0h exp 1", id_ready); else n_pass++;
        tick();
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (dut.busy_q !== 8'h34 || ex_op_a !== 32'd7) $display("FAIL selfref_result got busy=%0h a=%0h exp 34/7", dut.busy_q, ex_op_a); else n_pass++;
    endtask

    task automatic test_bypass_both();
        set_wb(1'b1, 3'd6, 32'h66);
        set_id(1'b1, 3'd6, 3'd6, 3'd0, 1'b0); #1;
        n_chk++; if (id_ready !== 1'b1 || rf_write_data !== 32'h66) $display("FAIL both_drive got rdy=%0h wd=%0h exp 1/66", id_ready, rf_write_data); else n_pass++;
        tick();
        set_wb(1'b0, 3'd0, 32'h0);
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_op_a !== 32'h66 || ex_op_b !== 32'h66) $display("FAIL both_ops got %0h/%0h exp 66/66", ex_op_a, ex_op_b); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h34 || rf[6] !== 32'h66) $display("FAIL both_idle_wb got busy=%0h rf6=%0h exp 34/66", dut.busy_q, rf[6]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        set_wb(1'b1, 3'd7, 32'h77); #1;
        n_chk++; if (rf_write_enable !== 1'b0 || id_ready !== 1'b0) $display("FAIL mid_forced got we=%0h rdy=%0h exp 0/0", rf_write_enable, id_ready); else n_pass++;
        tick();
        rst_n = 1'b1; #1;
        n_chk++; if (ex_valid !== 1'b0 || ex_op_a !== 32'h0 || ex_op_b !== 32'h0) $display("FAIL mid_ex_clear got v=%0h a=%0h b=%0h exp 0/0/0", ex_valid, ex_op_a, ex_op_b); else n_pass++;
        n_chk++; if (dut.busy_q !== 8'h00 || stall_cnt !== 4'd0) $display("FAIL mid_state_clear got busy=%0h cnt=%0d exp 00/0", dut.busy_q, stall_cnt); else n_pass++;
        n_chk++; if (rf_write_enable !== 1'b1) $display("FAIL mid_wb_after got %0h exp 1", rf_write_enable); else n_pass++;
        tick();
        set_wb(1'b0, 3'd0, 32'h0);
        set_id(1'b1, 3'd7, 3'd0, 3'd0, 1'b0);
        tick();
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_op_a !== 32'h77) $display("FAIL mid_rf_written got %0h exp 77", ex_op_a); else n_pass++;
    endtask

    task automatic test_saturation();
        ex_ready = 1'b1;
        set_id(1'b1, 3'd0, 3'd0, 3'd7, 1'b1);
        tick();
        set_id(1'b1, 3'd7, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        n_chk++; if (stall_cnt !== 4'd15) $display("FAIL sat_cnt got %0d exp 15", stall_cnt); else n_pass++;
        n_chk++; if (id_ready !== 1'b0) $display("FAIL sat_stalled got %0h exp 0", id_ready); else n_pass++;
        set_wb(1'b1, 3'd7, 32'h5A);
        tick();
        set_wb(1'b0, 3'd0, 32'h0);
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0); #1;
        n_chk++; if (ex_op_a !== 32'h5A || stall_cnt !== 4'd15) $display("FAIL sat_release got a=%0h cnt=%0d exp 5a/15", ex_op_a, stall_cnt); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 32'h0;
        rst_n = 1'b0; ex_ready = 1'b0;
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        set_wb(1'b0, 3'd0, 32'h0);
        test_reset();
        test_issue();
        test_raw();
        test_backpressure();
        test_waw();
        test_bypass_both();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
